data_ram_responder: RTL and testbench

//   Responder end of the CPU data-memory port: accepts read/write requests from
//   the pipeline (data_ram_ena / data_ram_wea / alu_result / mem_wdata) and

---
 rtl/data_ram_responder.sv | 102 ++++++++++
 tb/tb_data_ram_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_ram_responder.sv
// data_ram_responder
//   Responder for the CPU data-memory port. Accepts one read or write request
//   at a time, waits WAIT_CYCLES cycles, then completes it with a one-cycle
//   mem_ready pulse. Storage is word-addressed from the byte address. A
//   misaligned or out-of-range address is a fault. A faulted request does not
//   touch storage, raises addr_err with mem_ready, and has the same timing as a
//   good request.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   data_ram_ena   request valid (sampled only in IDLE)
//   data_ram_wea   1 = write, 0 = read
//   alu_result     byte address
//   mem_wdata      write data
//   mem_rdata      last completed read data
//   mem_ready      completion pulse
//   addr_err       fault flag, coincident with mem_ready
//   busy           request in flight
module data_ram_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ram_ena,
  input  logic        data_ram_wea,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        addr_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_d;
  logic [3:0]        cnt;
  logic [31:0]       addr_q, wdata_q;
  logic              we_q, fault_q;
  logic [31:0]       mem [DEPTH];

  // Access operands. With WAIT_CYCLES==0 the commit happens on the accept
  // edge itself, before the latched copies exist, so use the live inputs in IDLE.
  logic [31:0]       acc_addr, acc_wdata;
  logic              acc_we, acc_fault, commit;
  logic [ADDR_W-1:0] acc_idx;

  always_comb begin
    acc_addr  = (state == S_IDLE) ? alu_result   : addr_q;
    acc_wdata = (state == S_IDLE) ? mem_wdata    : wdata_q;
    acc_we    = (state == S_IDLE) ? data_ram_wea : we_q;
    acc_idx   = acc_addr[ADDR_W+1:2];
    acc_fault = (|acc_addr[1:0]) | (|acc_addr[31:ADDR_W+2]);
    // State only enters RESP from IDLE or WAIT, so this is the edge into RESP.
    commit    = (state_d == S_RESP) && !rst;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (data_ram_ena) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt == 4'(WAIT_CYCLES - 1)) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && data_ram_ena) begin
        addr_q  <= alu_result;
        wdata_q <= mem_wdata;
        we_q    <= data_ram_wea;
        fault_q <= acc_fault;
        cnt     <= '0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 4'd1;
      end
      if (commit && !acc_we && !acc_fault) mem_rdata <= mem[acc_idx];
    end
  end

  // Storage has no reset; rst only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_fault) mem[acc_idx] <= acc_wdata;
  end

  assign mem_ready = (state == S_RESP);
  assign addr_err  = mem_ready & fault_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_data_ram_responder.sv
module tb_data_ram_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance a: WAIT_CYCLES=2, instance b: WAIT_CYCLES=0
  logic        a_ena = 0, a_we = 0, a_ready, a_err, a_busy;
  logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
  logic        b_ena = 0, b_we = 0, b_ready, b_err, b_busy;
  logic [31:0] b_addr = 0, b_wdata = 0, b_rdata;

  data_ram_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .data_ram_ena(a_ena), .data_ram_wea(a_we),
    .alu_result(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
    .mem_ready(a_ready), .addr_err(a_err), .busy(a_busy));

  data_ram_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .data_ram_ena(b_ena), .data_ram_wea(b_we),
    .alu_result(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .mem_ready(b_ready), .addr_err(b_err), .busy(b_busy));

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request on instance a; returns response and latency in cycles
  // after the accept edge. With noise set, a different write is presented
  // during WAIT and RESP and must be ignored.
  task automatic req_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit noise, output logic [31:0] rdata, output logic err,
                       output int lat, output logic busy_ok);
    bit done = 0;
    a_ena = 1; a_we = we; a_addr = addr; a_wdata = wdata;
    busy_ok = 1; lat = 99; rdata = '0; err = 0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge clk);
      if (a_busy !== 1'b1) busy_ok = 0;
      if (a_ready === 1'b1) begin
        done = 1; lat = n; rdata = a_rdata; err = a_err;
      end else if (noise && n == 2) begin
        a_ena = 1; a_we = 1; a_addr = 32'h44; a_wdata = 32'hFFFF_FFFF;
      end else begin
        a_ena = 0;
      end
    end
    a_ena = 0;
  endtask

  task automatic wr_a(input string tag, input logic [31:0] addr, input logic [31:0] d,
                      input logic exp_err);
    logic [31:0] r; logic e, bo; int lat;
    req_a(1'b1, addr, d, 1'b0, r, e, lat, bo);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    @(negedge clk);
  endtask

  task automatic rd_a(input string tag, input logic [31:0] addr, input logic [31:0] exp,
                      input logic exp_err);
    logic [31:0] r; logic e, bo; int lat;
    req_a(1'b0, addr, '0, 1'b0, r, e, lat, bo);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    chk({tag, "_data"}, r, exp);
    @(negedge clk);
  endtask

  logic [31:0] wv [3];
  logic [31:0] r;
  logic        e, bo, any_rdy;
  int          lat, idx;

  initial begin
    wv[0] = 32'h1111_0000; wv[1] = 32'h2222_0004; wv[2] = 32'h3333_0008;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, a_ready}, 32'd0);
    chk("rst_busy",  {31'b0, a_busy},  32'd0);
    chk("rst_err",   {31'b0, a_err},   32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    rst = 0;
    @(negedge clk);

    // 1) write then read, WAIT=2
    req_a(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, r, e, lat, bo);
    chk("t1_wr_lat",  32'(lat), 32'd3);
    chk("t1_wr_err",  {31'b0, e}, 32'd0);
    chk("t1_wr_busy", {31'b0, bo}, 32'd1);
    @(negedge clk);
    chk("t1_idle_busy", {31'b0, a_busy}, 32'd0);
    rd_a("t1_rd", 32'h10, 32'hDEAD_BEEF, 1'b0);

    // 3) faults: misaligned read keeps rdata; out-of-range write leaves mem[0]
    rd_a("t3_mis", 32'h13, 32'hDEAD_BEEF, 1'b1);
    wr_a("t3_w0", 32'h0, 32'h1111_1111, 1'b0);
    wr_a("t3_oor", 32'h1000, 32'h5A5A_5A5A, 1'b1);
    rd_a("t3_m0", 32'h0, 32'h1111_1111, 1'b0);

    // 4) top word, no wrap
    wr_a("t4_wr", 32'hFFC, 32'h1234_5678, 1'b0);
    rd_a("t4_rd", 32'hFFC, 32'h1234_5678, 1'b0);
    rd_a("t4_m0", 32'h0, 32'h1111_1111, 1'b0);

    // 5) reset during WAIT aborts the write
    wr_a("t5_pre", 32'h20, 32'h0BAD_F00D, 1'b0);
    a_ena = 1; a_we = 1; a_addr = 32'h20; a_wdata = 32'hAAAA_5555;
    @(negedge clk);
    chk("t5_busy", {31'b0, a_busy}, 32'd1);
    a_ena = 0; rst = 1;
    @(negedge clk);
    chk("t5_ready", {31'b0, a_ready}, 32'd0);
    chk("t5_bsy0",  {31'b0, a_busy},  32'd0);
    chk("t5_err",   {31'b0, a_err},   32'd0);
    chk("t5_rdata", a_rdata, 32'd0);
    rst = 0;
    any_rdy = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_ready !== 1'b0) any_rdy = 1;
    end
    chk("t5_no_rdy", {31'b0, any_rdy}, 32'd0);
    rd_a("t5_rd", 32'h20, 32'h0BAD_F00D, 1'b0);

    // 6) ena/addr/data changes during WAIT and RESP are ignored
    wr_a("t6_pre", 32'h44, 32'h4444_4444, 1'b0);
    req_a(1'b1, 32'h40, 32'hCAFE_F00D, 1'b1, r, e, lat, bo);
    chk("t6_lat", 32'(lat), 32'd3);
    chk("t6_err", {31'b0, e}, 32'd0);
    @(negedge clk);
    chk("t6_idle", {31'b0, a_busy}, 32'd0);
    rd_a("t6_r40", 32'h40, 32'hCAFE_F00D, 1'b0);
    rd_a("t6_r44", 32'h44, 32'h4444_4444, 1'b0);

    // 2) WAIT=0, ena held high: ready every second cycle
    idx = 0;
    b_ena = 1; b_we = 1; b_addr = 32'h0; b_wdata = wv[0];
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("t2_wr_rdy", {31'b0, b_ready}, {31'b0, (i % 2) == 1});
      if (b_ready === 1'b1) begin
        chk("t2_wr_err", {31'b0, b_err}, 32'd0);
        if (idx < 2) begin
          idx++; b_addr = 32'(idx * 4); b_wdata = wv[idx];
        end
      end
    end
    idx = 0; b_we = 0; b_addr = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("t2_rd_rdy", {31'b0, b_ready}, {31'b0, (i % 2) == 0});
      if (b_ready === 1'b1 && idx < 3) begin
        chk("t2_rd_data", b_rdata, wv[idx]);
        idx++; b_addr = 32'(idx * 4);
      end
    end
    b_ena = 0;
    @(negedge clk);
    chk("t2_idle", {31'b0, b_busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
